// File: rtl/sd_clk_ctrl_defines.sv
// Shared constants for the SD clock controller: FSM encodings, divider width
// and the card-identification divider.
package sd_clk_ctrl_defines;

    localparam int DIV_W = 8;

    // 400 kHz identification clock from a 100 MHz CLK
    localparam logic [DIV_W-1:0] SD_ID_DIV = 8'd124;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_DRAIN = 3'd1,
        ST_LOAD  = 3'd2,
        ST_INIT  = 3'd3,
        ST_RUN   = 3'd4
    } state_t;

endpackage

// File: rtl/sd_clk_edge_counter.sv
// SD_CLK rising-edge detector with an 8-bit saturating rise counter.
module sd_clk_edge_counter (
    input  logic       CLK,
    input  logic       RST,
    input  logic       sd_clk,
    input  logic       clr,
    output logic       rise,
    output logic [7:0] count
);

    logic sd_clk_q;

    assign rise = sd_clk & ~sd_clk_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            sd_clk_q <= 1'b0;
            count    <= '0;
        end else begin
            sd_clk_q <= sd_clk;
            if (clr)
                count <= '0;
            else if (rise && count != 8'hFF)
                count <= count + 8'd1;
        end
    end

endmodule

// File: rtl/sd_clock_ctrl.sv
// SD clock divider sequencer: power-up clocking and glitch-free divider changes.
// Optional SD_CLK_AUTOGATE_EN adds CLK_GATE to park SD_CLK while the bus is idle.
module sd_clock_ctrl
    import sd_clk_ctrl_defines::*;
#(
    parameter logic [DIV_W-1:0] DEFAULT_DIV = SD_ID_DIV,
    parameter int               INIT_CLOCKS = 80,
    parameter int               HOLD_CYCLES = 2
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             REQ_VALID,
    input  logic [DIV_W-1:0] REQ_DIV,
    output logic             REQ_ACK,
    input  logic             BUS_BUSY,
    input  logic             INIT_START,
    output logic             INIT_DONE,
    input  logic             SD_CLK,
    output logic [DIV_W-1:0] DIVIDER,
    output logic             DIV_RST
`ifdef SD_CLK_AUTOGATE_EN
    ,
    input  logic             CLK_GATE
`endif
);

    state_t           state, state_nxt;
    logic [3:0]       hold_cnt;
    logic             init_pending;
    logic [DIV_W-1:0] div_next;
    logic             gated, gate_nxt;
    logic             rise, edge_clr, ack_nxt;
    logic [7:0]       edge_cnt;
    logic             hold_done, init_hit;

    assign hold_done = (hold_cnt == 4'(HOLD_CYCLES - 1));
    assign init_hit  = rise && (edge_cnt == 8'(INIT_CLOCKS - 1));

    sd_clk_edge_counter u_edge (
        .CLK    (CLK),
        .RST    (RST),
        .sd_clk (SD_CLK),
        .clr    (edge_clr),
        .rise   (rise),
        .count  (edge_cnt)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= ST_LOAD;
        else     state <= state_nxt;
    end

    // INIT_START overrides everything, including a request in flight
    always_comb begin
        state_nxt = state;
        if (INIT_START) begin
            state_nxt = ST_LOAD;
        end else begin
            case (state)
                ST_IDLE:  state_nxt = ST_IDLE;
                ST_DRAIN: if (!BUS_BUSY) state_nxt = ST_LOAD;
                ST_LOAD:  if (hold_done) state_nxt = init_pending ? ST_INIT : ST_RUN;
                ST_INIT:  if (init_hit) state_nxt = ST_RUN;
                ST_RUN:   if (REQ_VALID) state_nxt = BUS_BUSY ? ST_DRAIN : ST_LOAD;
                default:  state_nxt = ST_LOAD;
            endcase
        end
    end

    always_comb begin
        DIV_RST  = (state == ST_LOAD) | gated;
        edge_clr = (state == ST_LOAD);
        ack_nxt  = (state == ST_LOAD) && hold_done && !init_pending && !INIT_START;
`ifdef SD_CLK_AUTOGATE_EN
        gate_nxt = (state_nxt == ST_RUN) && CLK_GATE && !BUS_BUSY;
`else
        gate_nxt = 1'b0;
`endif
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            DIVIDER      <= DEFAULT_DIV;
            div_next     <= DEFAULT_DIV;
            hold_cnt     <= '0;
            init_pending <= 1'b1;
            INIT_DONE    <= 1'b0;
            REQ_ACK      <= 1'b0;
            gated        <= 1'b0;
        end else begin
            REQ_ACK <= ack_nxt;
            gated   <= gate_nxt;
            if (state == ST_LOAD && !INIT_START) hold_cnt <= hold_cnt + 4'd1;
            else                                 hold_cnt <= '0;
            if (state == ST_RUN && REQ_VALID && !INIT_START) div_next <= REQ_DIV;
            if (INIT_START) begin
                INIT_DONE    <= 1'b0;
                init_pending <= 1'b1;
                DIVIDER      <= DEFAULT_DIV;
            end else begin
                // DIVIDER only moves on the cycle LOAD is entered
                if (state == ST_RUN && REQ_VALID && !BUS_BUSY)
                    DIVIDER <= REQ_DIV;
                else if (state == ST_DRAIN && !BUS_BUSY)
                    DIVIDER <= div_next;
                if (state == ST_INIT && init_hit) begin
                    INIT_DONE    <= 1'b1;
                    init_pending <= 1'b0;
                end
            end
        end
    end

endmodule

// File: doc/sd_clock_ctrl.md
Name: sd_clock_ctrl

Overview:
- Sequences the SD card clock divider.
- After reset or on command, runs the card power-up sequence: identification-rate divider, then INIT_CLOCKS SD_CLK rising edges with the bus idle.
- Applies host divider changes glitch-free: waits for the bus to go idle, parks the divider in reset, loads the new value, then releases it.
- Sits between the SD host register block / init FSM and the clock divider.
- The divider toggles SD_CLK every DIVIDER+1 CLK cycles, so f_SD = f_CLK / (2·(DIVIDER+1)).

Parameters:
- DEFAULT_DIV, 8'd124: identification divider (400 kHz from 100 MHz).
- INIT_CLOCKS, 80: SD_CLK rising edges in the power-up sequence; range 1..255.
- HOLD_CYCLES, 2: CLK cycles DIV_RST is held when loading a divider; range 1..15.

Ports:
- CLK  in  1  system clock
- RST  in  1  reset: asynchronous, active-high, clock CLK
- REQ_VALID  in  1  divider change request; held until REQ_ACK
- REQ_DIV  in  8  requested divider; stable while REQ_VALID
- REQ_ACK  out  1  one-cycle pulse: new divider applied and clock released
- BUS_BUSY  in  1  CMD/DAT transfer in progress
- INIT_START  in  1  one-cycle pulse: restart power-up sequence
- INIT_DONE  out  1  high once the power-up sequence completes
- SD_CLK  in  1  divider output, fed back; synchronous to CLK
- DIVIDER  out  8  divider value to the clock divider
- DIV_RST  out  1  holds the divider (counter and SD_CLK) in reset, SD_CLK low
- CLK_GATE  in  1  present only with SD_CLK_AUTOGATE_EN

Behaviour:
- Reset values: DIVIDER=DEFAULT_DIV, DIV_RST=1, REQ_ACK=0, INIT_DONE=0, state=LOAD, hold counter=0, edge counter=0, init_pending=1.
- Edge detect: sd_clk_q <= SD_CLK every cycle; rise = SD_CLK & ~sd_clk_q.
- States:
  - IDLE: INIT_DONE=0, clock released, waiting for INIT_START.
  - DRAIN: wait for BUS_BUSY=0.
  - LOAD: DIV_RST=1 for HOLD_CYCLES cycles; DIVIDER updated on entry.
  - INIT: DIV_RST=0; count rising edges.
  - RUN: clock free-running.
- LOAD exit:
  - If init_pending: go to INIT, clear edge counter.
  - Otherwise: pulse REQ_ACK in the cycle DIV_RST falls, go to RUN.
- INIT: BUS_BUSY is ignored. On the INIT_CLOCKS-th rise: INIT_DONE<=1, init_pending<=0, go to RUN. Edge counter is 8 bits and saturates.
- RUN with REQ_VALID=1:
  - Latch REQ_DIV into div_next.
  - If BUS_BUSY=1, go to DRAIN; otherwise go directly to LOAD.
  - DRAIN goes to LOAD on the first cycle BUS_BUSY=0.
  - DIVIDER<=div_next on LOAD entry.
- REQ_ACK latency with bus idle: request accepted at cycle t; DIV_RST high t+1..t+HOLD_CYCLES; ACK at t+HOLD_CYCLES+1.
- REQ_VALID still high in the cycle after ACK is a new request.
- REQ_VALID in IDLE/INIT/LOAD/DRAIN: not accepted and not acked; it stays pending until RUN.
- INIT_START in any state, including mid-DRAIN or mid-LOAD:
  - INIT_DONE<=0, init_pending<=1, DIVIDER<=DEFAULT_DIV, go to LOAD.
  - A request in flight is not acked; it is re-accepted from RUN.
  - INIT_START and REQ_VALID in the same cycle: INIT_START wins.
- REQ_DIV=0 is legal: f_CLK/2.
- An equal divider still runs the full LOAD sequence.

Optional Feature:
- Macro: SD_CLK_AUTOGATE_EN.
- With macro:
  - CLK_GATE port exists.
  - In RUN with CLK_GATE=1 and BUS_BUSY=0: DIV_RST=1, SD_CLK parked low.
  - Clock resumes the cycle after either condition drops.
  - Gating is never applied in INIT or LOAD.
  - A request arriving while gated is accepted normally.
- Without macro: no CLK_GATE port; the clock is free-running in RUN.

Decomposition:
- Shared package/include file sd_clk_ctrl_defines:
  - 3-bit state encodings: IDLE=0, DRAIN=1, LOAD=2, INIT=3, RUN=4.
  - Divider width constant (8).
  - DEFAULT_DIV identification constant.
- One sub-module, sd_clk_edge_counter: SD_CLK edge detect plus 8-bit saturating rise counter with clear. Everything else is in the top FSM.

Test Plan:
- Reset, BUS_BUSY=0, DEFAULT_DIV=124 → DIV_RST high 2 cycles after RST falls, DIVIDER=124; INIT_DONE rises on the 80th SD_CLK rise (≈20 000 CLK cycles later); REQ_ACK never pulses.
- In RUN, REQ_VALID with REQ_DIV=0, BUS_BUSY=0 at cycle t → DIV_RST high t+1..t+2, REQ_ACK at t+3, DIVIDER=0, SD_CLK period 2 CLK cycles.
- Request with BUS_BUSY=1 for 50 cycles → DIVIDER unchanged and DIV_RST low throughout busy; LOAD starts the first cycle BUS_BUSY=0; ACK 3 cycles later.
- INIT_START during DRAIN with REQ_VALID held → no ACK; DIVIDER=124; INIT_DONE drops then re-rises after 80 edges; ACK follows from RUN with the requested value.
- INIT_START and REQ_VALID in the same cycle → init sequence runs first; REQ_ACK only after INIT_DONE=1.
- With SD_CLK_AUTOGATE_EN, CLK_GATE=1, BUS_BUSY=0 in RUN → DIV_RST=1 and SD_CLK low; BUS_BUSY=1 → clock resumes next cycle.
